// File: rtl/dmem_if.sv
// dmem_if: valid/ready request and response channels between the core load/store path and the data memory.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic [2:0]  req_load_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master(
        output req_valid, req_wr, req_addr, req_wdata, req_mask, req_load_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave(
        input  req_valid, req_wr, req_addr, req_wdata, req_mask, req_load_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with internal RAM, byte-masked stores, extended loads and wait states.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses with rsp_err instead of performing them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [AW+1:0] hold_addr, a_addr;
    logic          hold_wr, a_wr;
    logic [31:0]   hold_wdata, a_wdata;
    logic [3:0]    hold_mask, a_mask;
    logic [2:0]    hold_ctrl, a_ctrl;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   word, ext, rdata;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          err, idle_go, last, commit, misalign;
    assign idle_go = state == IDLE && bus.req_valid;
    assign last    = state == WAIT && cnt == CW'(WAIT_CYCLES - 1);
    // Gated by rst so a zero-wait request arriving during reset never reaches storage
    assign commit  = rst && (last || (idle_go && WAIT_CYCLES == 0));
    assign a_addr  = state == IDLE ? bus.req_addr[AW+1:0] : hold_addr;
    assign a_wr    = state == IDLE ? bus.req_wr : hold_wr;
    assign a_wdata = state == IDLE ? bus.req_wdata : hold_wdata;
    assign a_mask  = state == IDLE ? bus.req_mask : hold_mask;
    assign a_ctrl  = state == IDLE ? bus.req_load_ctrl : hold_ctrl;
    assign word    = mem[a_addr[AW+1:2]];
    assign lane_b  = word[8*a_addr[1:0] +: 8];
    assign lane_h  = a_addr[1] ? word[31:16] : word[15:0];
    always_comb begin
        ext = word;
        case (a_ctrl)
            3'b000:  ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  ext = {24'd0, lane_b};
            3'b101:  ext = {16'd0, lane_h};
            default: ext = word;
        endcase
    end
`ifdef DMEM_MISALIGN_ERR_EN
    always_comb begin
        misalign = a_wr
            ? !(a_mask inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
            : ((a_ctrl[1:0] == 2'b01 && a_addr[0]) || (a_ctrl == 3'b010 && a_addr[1:0] != 2'b00));
    end
`else
    assign misalign = 1'b0;
`endif
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
            end
            WAIT:    state_nx = last ? RESP : WAIT;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            hold_addr  <= '0;
            hold_wr    <= 1'b0;
            hold_wdata <= '0;
            hold_mask  <= '0;
            hold_ctrl  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == WAIT && !last) ? cnt + 1'b1 : '0;
            if (idle_go) begin
                hold_addr  <= bus.req_addr[AW+1:0];
                hold_wr    <= bus.req_wr;
                hold_wdata <= bus.req_wdata;
                hold_mask  <= bus.req_mask;
                hold_ctrl  <= bus.req_load_ctrl;
            end
            if (commit) begin
                rdata <= (a_wr || misalign) ? '0 : ext;
                err   <= misalign;
            end else if (state == RESP && bus.rsp_ready) begin
                rdata <= '0;
                err   <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (commit && a_wr && !misalign)
            for (int i = 0; i < 4; i++)
                if (a_mask[i]) mem[a_addr[AW+1:2]][8*i +: 8] <= a_wdata[8*i +: 8];
    end
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a 2-wait-state responder and a zero-wait responder sharing one stimulus driver.
module tb_dmem_responder;
    logic        clk = 1'b0, rst = 1'b0, sel = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_mask = '0;
    logic [2:0]  req_ctrl = '0;
    logic        rv, rdy, re, e;
    logic [31:0] rd, d;
    int          total = 0, bad = 0;
    dmem_if b2();
    dmem_if b0();
    assign b2.req_valid     = req_valid & ~sel;
    assign b0.req_valid     = req_valid & sel;
    assign b2.rsp_ready     = rsp_ready & ~sel;
    assign b0.rsp_ready     = rsp_ready & sel;
    assign b2.req_wr        = req_wr;
    assign b0.req_wr        = req_wr;
    assign b2.req_addr      = req_addr;
    assign b0.req_addr      = req_addr;
    assign b2.req_wdata     = req_wdata;
    assign b0.req_wdata     = req_wdata;
    assign b2.req_mask      = req_mask;
    assign b0.req_mask      = req_mask;
    assign b2.req_load_ctrl = req_ctrl;
    assign b0.req_load_ctrl = req_ctrl;
    assign rv  = sel ? b0.rsp_valid : b2.rsp_valid;
    assign rdy = sel ? b0.req_ready : b2.req_ready;
    assign rd  = sel ? b0.rsp_rdata : b2.rsp_rdata;
    assign re  = sel ? b0.rsp_err   : b2.rsp_err;
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut  (.clk(clk), .rst(rst), .bus(b2));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // One full transaction; request inputs are scrambled after acceptance to prove they were captured
    task automatic xact(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input logic [2:0] ctrl, input int hold,
                        output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_mask = mask; req_ctrl = ctrl;
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_mask = 4'hF; req_ctrl = 3'b011;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv && n < 20);
        check({tag, "_lat"}, n, sel ? 1 : 3);
        check({tag, "_busy"}, {31'd0, rdy}, 0);
        rdata = rd;
        err = re;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, rv}, 1);
            check({tag, "_hold_data"}, rd, rdata);
            check({tag, "_hold_ready"}, {31'd0, rdy}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check({tag, "_done_valid"}, {31'd0, rv}, 0);
        check({tag, "_done_data"}, rd, 0);
        check({tag, "_done_ready"}, {31'd0, rdy}, 1);
    endtask
    task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] ctrl, input logic [31:0] exp);
        xact(tag, 1'b0, addr, 32'h0, 4'h0, ctrl, 0, d, e);
        check(tag, d, exp);
        check({tag, "_err"}, {31'd0, e}, 0);
    endtask
    task automatic st(input string tag, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        xact(tag, 1'b1, addr, wdata, mask, 3'b010, 0, d, e);
        check(tag, d, 0);
        check({tag, "_err"}, {31'd0, e}, 0);
    endtask
    initial begin
        #1;
        check("rst_valid", {31'd0, rv}, 0);
        check("rst_ready", {31'd0, rdy}, 1);
        check("rst_rdata", rd, 0);
        check("rst_err", {31'd0, re}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        st("sw_10", 32'h10, 32'hDEAD_BEEF, 4'b1111);
        ld("lw_10", 32'h10, 3'b010, 32'hDEAD_BEEF);
        st("sb_21", 32'h21, 32'h0000_8000, 4'b0010);
        ld("lb_21", 32'h21, 3'b000, 32'hFFFF_FF80);
        ld("lbu_21", 32'h21, 3'b100, 32'h0000_0080);
        st("sh_22", 32'h22, 32'h8001_0000, 4'b1100);
        ld("lh_22", 32'h22, 3'b001, 32'hFFFF_8001);
        ld("lhu_22", 32'h22, 3'b101, 32'h0000_8001);
        st("sw_30", 32'h30, 32'h1234_5678, 4'b1111);
        ld("lb_33", 32'h33, 3'b000, 32'h0000_0012);
        ld("lbu_30", 32'h30, 3'b100, 32'h0000_0078);
        ld("lh_30", 32'h30, 3'b001, 32'h0000_5678);
        ld("rsvd_31", 32'h31, 3'b011, 32'h1234_5678);
        st("mask0_10", 32'h10, 32'h0000_0000, 4'b0000);
        ld("lw_10_kept", 32'h10, 3'b010, 32'hDEAD_BEEF);
        ld("lw_wrap", 32'h1010, 3'b010, 32'hDEAD_BEEF);
        xact("bp", 1'b0, 32'h10, 32'h0, 4'h0, 3'b010, 5, d, e);
        check("bp_data", d, 32'hDEAD_BEEF);
        st("sw_40", 32'h40, 32'h1111_1111, 4'b1111);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h40; req_wdata = 32'h2222_2222; req_mask = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_valid", {31'd0, rv}, 0);
        check("abort_ready", {31'd0, rdy}, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rv}, 0);
        end
        ld("lw_40_old", 32'h40, 3'b010, 32'h1111_1111);
        sel = 1'b1;
        st("z_sw_0", 32'h0, 32'h0000_1234, 4'b1111);
        ld("z_lw_1000", 32'h1000, 3'b010, 32'h0000_1234);
        sel = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        xact("mis_lw", 1'b0, 32'h6, 32'h0, 4'h0, 3'b010, 0, d, e);
        check("mis_lw_err", {31'd0, e}, 1);
        check("mis_lw_data", d, 0);
        xact("mis_sw", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0110, 3'b010, 0, d, e);
        check("mis_sw_err", {31'd0, e}, 1);
        ld("mis_sw_kept", 32'h10, 3'b010, 32'hDEAD_BEEF);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory interface: it accepts load/store requests over a valid/ready handshake and answers with a response beat.
- Stores apply the byte mask; loads return lane-extracted data, sign- or zero-extended according to load_ctrl.
- Adds a programmable wait-state count so the core can be moved off the single-cycle data memory and exercised against realistic memory latency.
- Sits between the core's load/store path and backing RAM storage held inside this block.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage; must be a power of two.
- WAIT_CYCLES, 2, extra cycles between request acceptance and response valid; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already lane-aligned.
- req_mask  in  4  byte enables for stores; bit i enables byte lane i.
- req_load_ctrl  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  error response (optional feature only).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr, wr, wdata, mask and load_ctrl into holding registers; go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0.
  - The counter counts up from 0; at count WAIT_CYCLES-1, go to RESP.
- Storage access: happens on the edge leaving the last WAIT cycle (or leaving IDLE when WAIT_CYCLES=0).
  - Store: write only the bytes enabled in mask.
  - Load: register the word.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until the handshake completes.
  - On rsp_ready, go to IDLE, drop rsp_valid and clear rsp_rdata to 0.
- Latency: first rsp_valid appears WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: at most one request in flight; req_ready=0 in WAIT and RESP.
- Word index: req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Load extraction, using a = addr[1:0]:
  - LB/LBU: byte a.
  - LH/LHU: halfword at a[1].
  - LW: full word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Reserved load_ctrl codes return the full word.
- Store with mask=0000: no bytes written, but a response is still returned.
- rsp_ready held high while in IDLE or WAIT has no effect.
- Reset mid-operation: the transaction is aborted and no response is produced. A store already committed to storage stays written; one not yet committed is dropped.
- Inputs are sampled only on the accepting edge; later changes on the request inputs are ignored.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - A misaligned access raises an error: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - Store misalignment is inferred from the mask: not 4'b1111 and not a legal aligned byte or halfword pattern.
  - Result: rsp_err=1, no storage write, rsp_rdata=0.
  - Latency is unchanged.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned halfword/word accesses ignore addr[1:0] for the word and use the lanes given by mask (stores) or by the alignment rule above (loads).

Test Plan:
- Reset/idle: drive rst low mid-WAIT with WAIT_CYCLES=2 -> rsp_valid=0 and req_ready=1 immediately; after release, no stale response appears.
- Word round trip: SW addr 0x10, data 0xDEADBEEF, mask 1111; then LW 0x10 -> rsp_rdata=0xDEADBEEF; rsp_valid first rises exactly 3 cycles after each accept.
- Byte/half extension: SB 0x80 to addr 0x21 (mask 0010, wdata 0x00008000) -> LB 0x21 gives 0xFFFFFF80, LBU 0x21 gives 0x00000080; SH 0x8001 at 0x22 -> LH 0x22 gives 0xFFFF8001, LHU gives 0x00008001.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid stays 1, rsp_rdata stays stable, req_ready stays 0; on rsp_ready=1 the state returns to IDLE next cycle.
- Wrap and zero wait: WAIT_CYCLES=0, DEPTH_WORDS=1024; SW 0x1234 to addr 0x0, then LW addr 0x1000 -> 0x00001234, response one cycle after accept.
- DMEM_MISALIGN_ERR_EN defined: LW addr 0x6 -> rsp_err=1, rsp_rdata=0; SW mask 0110 -> rsp_err=1 and the memory word is unchanged.
